// File: rtl/inst_fetch_unit_if.sv
// Memory read port and scheduler stream port of the instruction fetch unit.
// master = fetch unit side, slave = memory/scheduler side.
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [INST_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst_out;
  logic              inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_out,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_out,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: credit-limited memory reads into a prefetch FIFO feeding the scheduler.
// Optional FETCH_PERF_CNT_EN adds saturating memory-stall and output-stall cycle counters.
module inst_fetch_unit #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  inst_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_mem_stall,
  output logic [31:0]       perf_out_stall,
`endif
  inst_fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(INST_W / 8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]  req_left_q, req_left_d;
  logic [OCC_W-1:0]  outst_q, outst_d;
  logic [OCC_W-1:0]  fifo_cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [INST_W-1:0] fifo_mem_q [FIFO_DEPTH];

  logic credit_ok_s, req_s, grant_s, flush_s, push_s, pop_s;

  // Entries already buffered plus reads in flight must leave room for one more response.
  assign credit_ok_s = ((OCC_W+1)'(fifo_cnt_q) + (OCC_W+1)'(outst_q)) < (OCC_W+1)'(FIFO_DEPTH);
  assign req_s       = (state_q == S_FETCH) && !abort && (req_left_q != '0) && credit_ok_s;
  assign grant_s     = req_s && bus.mem_gnt;
  assign flush_s     = abort && (state_q != S_IDLE);
  assign push_s      = bus.mem_rvalid && !flush_s && ((state_q == S_FETCH) || (state_q == S_DRAIN));
  assign pop_s       = bus.inst_valid && bus.inst_ready;

  assign bus.mem_req    = req_s;
  assign bus.mem_addr   = req_addr_q;
  assign bus.inst_valid = (fifo_cnt_q != '0);
  assign bus.inst_out   = fifo_mem_q[rd_ptr_q];
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign aborted        = (state_q == S_FLUSH) && (outst_q == '0);

  // Next state, request address and remaining-count update.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_left_d = req_left_q;
    if (flush_s && (state_q != S_FLUSH)) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            req_addr_d = base_addr;
            req_left_d = inst_count;
            state_d    = (inst_count == '0) ? S_DONE : S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (grant_s) begin
            req_addr_d = req_addr_q + ADDR_STEP;
            req_left_d = req_left_q - CNT_W'(1);
            state_d    = (req_left_q == CNT_W'(1)) ? S_DRAIN : S_FETCH;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if ((outst_q == '0) && (fifo_cnt_q == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_FLUSH: begin
          if (outst_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FLUSH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outstanding reads: grant adds one, response removes one, both together cancel.
  always_comb begin
    outst_d = outst_q;
    case ({grant_s, bus.mem_rvalid})
      2'b10:   outst_d = outst_q + OCC_W'(1);
      2'b01:   outst_d = outst_q - OCC_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_left_q <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_left_q <= req_left_d;
      outst_q    <= outst_d;
    end
  end

  // Prefetch FIFO; abort empties it so discarded data never reaches the scheduler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else if (flush_s) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= bus.mem_rdata;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + OCC_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - OCC_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_mem_q, perf_out_q;

  // Stall counters restart with each accepted start and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mem_q <= 32'd0;
      perf_out_q <= 32'd0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_mem_q <= 32'd0;
      perf_out_q <= 32'd0;
    end else begin
      if (req_s && !bus.mem_gnt && (perf_mem_q != 32'hFFFF_FFFF)) perf_mem_q <= perf_mem_q + 32'd1;
      if (bus.inst_valid && !bus.inst_ready && (perf_out_q != 32'hFFFF_FFFF)) perf_out_q <= perf_out_q + 32'd1;
    end
  end

  assign perf_mem_stall = perf_mem_q;
  assign perf_out_stall = perf_out_q;
`endif

  inst_fetch_unit_chk #(.OCC_W(OCC_W)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .rvalid (bus.mem_rvalid),
    .outst  (outst_q)
  );
endmodule

// Protocol checker: memory must never return data that was not requested.
module inst_fetch_unit_chk #(
  parameter int OCC_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             rvalid,
  input logic [OCC_W-1:0] outst
);
  a_rvalid_has_credit: assert property (@(posedge clk) disable iff (!rst_n) rvalid |-> (outst != '0));
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: memory responder, output monitor and directed scenarios.
`timescale 1ns/1ps
module tb_inst_fetch_unit;
  localparam int ADDR_W = 32;
  localparam int INST_W = 64;
  localparam int CNT_W  = 16;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  inst_count = '0;
  logic              busy, done, aborted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       perf_mem_stall, perf_out_stall;
`endif

  inst_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus_if ();

  inst_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .FIFO_DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .inst_count (inst_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
`ifdef FETCH_PERF_CNT_EN
    .perf_mem_stall (perf_mem_stall),
    .perf_out_stall (perf_out_stall),
`endif
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } rsp_t;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_inst_q [$];
  rsp_t        rsp_q [$];
  int          hs_cnt = 0, done_cnt = 0, abort_cnt = 0, done_edge = 0, start_cyc = 0;
  int          stall_idx = -1, stall_left = 0;
  logic [31:0] stall_addr = '0;

  function automatic logic [63:0] inst_of(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: drives gnt/rvalid for the coming edge and checks every granted address.
  initial begin
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    bus_if.mem_rdata  = '0;
    forever begin
      @(negedge clk); #1;
      if (bus_if.mem_req && (stall_left > 0) && (hs_cnt == stall_idx)) begin
        bus_if.mem_gnt = 1'b0;
        stall_left--;
        chk("stall_addr_held", 64'(bus_if.mem_addr), 64'(stall_addr));
      end else begin
        bus_if.mem_gnt = 1'b1;
      end
      if ((rsp_q.size() > 0) && (rsp_q[0].due == cyc + 1)) begin
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = inst_of(rsp_q[0].addr);
        void'(rsp_q.pop_front());
      end else begin
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
      end
      if (bus_if.mem_req && bus_if.mem_gnt) begin
        hs_cnt++;
        if (exp_addr_q.size() == 0) chk("req_expected", 64'd0, 64'd1);
        else chk("mem_addr", 64'(bus_if.mem_addr), 64'(exp_addr_q.pop_front()));
        rsp_q.push_back('{due: cyc + 1 + LAT, addr: bus_if.mem_addr});
      end
    end
  end

  // Output monitor: pops the scoreboard on each transfer and tracks done/aborted pulses.
  initial begin
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (bus_if.inst_valid && bus_if.inst_ready) begin
        if (exp_inst_q.size() == 0) chk("inst_expected", 64'd0, 64'd1);
        else chk("inst_out", bus_if.inst_out, exp_inst_q.pop_front());
      end
      if (done && !done_prev) begin
        done_cnt++;
        done_edge = cyc + 1;
        chk("busy_with_done", 64'(busy), 64'd1);
      end
      if (done_prev) begin
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_after_done", 64'(busy), 64'd0);
      end
      if (aborted) abort_cnt++;
      done_prev = done;
    end
  end

  task automatic run_start(input logic [31:0] base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_addr_q.push_back(base + 32'(i * 8));
      exp_inst_q.push_back(inst_of(base + 32'(i * 8)));
    end
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    inst_count = CNT_W'(cnt);
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("first_req", 64'(bus_if.mem_req), (cnt > 0) ? 64'd1 : 64'd0);
  endtask

  task automatic wait_done(input string name);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while ((done_cnt == d0) && (n < 500)) begin
      @(negedge clk); #2;
      n++;
    end
    chk(name, 64'(done_cnt - d0), 64'd1);
    repeat (2) @(negedge clk);
    chk({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({name, "_inst_left"}, 64'(exp_inst_q.size()), 64'd0);
  endtask

  initial begin
    int hs0, d0, a0, n;
    bus_if.inst_ready = 1'b0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_mem_req", 64'(bus_if.mem_req), 64'd0);
    chk("rst_mem_addr", 64'(bus_if.mem_addr), 64'd0);
    chk("rst_inst_valid", 64'(bus_if.inst_valid), 64'd0);
    chk("rst_inst_out", bus_if.inst_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic stream
    bus_if.inst_ready = 1'b1;
    hs0 = hs_cnt;
    run_start(32'h0000_1000, 5);
    wait_done("basic_done");
    chk("basic_grants", 64'(hs_cnt - hs0), 64'd5);

    // Backpressure: FIFO fills, requests stop at the credit limit
    bus_if.inst_ready = 1'b0;
    hs0 = hs_cnt;
    run_start(32'h0000_4000, 20);
    repeat (30) @(negedge clk);
    chk("bp_grants", 64'(hs_cnt - hs0), 64'd8);
    chk("bp_req_low", 64'(bus_if.mem_req), 64'd0);
    chk("bp_valid_held", 64'(bus_if.inst_valid), 64'd1);
    chk("bp_head", bus_if.inst_out, inst_of(32'h0000_4000));
    bus_if.inst_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_total_grants", 64'(hs_cnt - hs0), 64'd20);

    // Zero count: done is captured two edges after start is raised
    hs0 = hs_cnt;
    run_start(32'h0000_5000, 0);
    wait_done("zero_done");
    chk("zero_done_lat", 64'(done_edge - start_cyc), 64'd2);
    chk("zero_no_req", 64'(hs_cnt - hs0), 64'd0);

    // Grant stall on the second request
    hs0        = hs_cnt;
    stall_idx  = hs_cnt + 1;
    stall_left = 4;
    stall_addr = 32'h0000_1008;
    run_start(32'h0000_1000, 4);
    wait_done("stall_done");
    chk("stall_cycles_used", 64'(stall_left), 64'd0);
    chk("stall_grants", 64'(hs_cnt - hs0), 64'd4);
    stall_idx = -1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_mem_stall", 64'(perf_mem_stall), 64'd4);
`endif

    // Abort after three grants with two reads outstanding
    hs0 = hs_cnt;
    d0  = done_cnt;
    a0  = abort_cnt;
    run_start(32'h0000_8000, 10);
    n = 0;
    while (((hs_cnt - hs0) < 3) && (n < 50)) begin
      @(negedge clk); #2;
      n++;
    end
    chk("abort_three_grants", 64'(hs_cnt - hs0), 64'd3);
    @(negedge clk);
    abort = 1'b1;
    #2;
    chk("abort_req_drop", 64'(bus_if.mem_req), 64'd0);
    @(posedge clk); #1;
    chk("abort_valid_low", 64'(bus_if.inst_valid), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    exp_addr_q.delete();
    exp_inst_q.delete();
    n = 0;
    while ((abort_cnt == a0) && (n < 50)) begin
      @(negedge clk); #2;
      n++;
    end
    chk("aborted_pulse", 64'(abort_cnt - a0), 64'd1);
    chk("abort_rsp_drained", 64'(rsp_q.size()), 64'd0);
    chk("abort_busy_in_pulse", 64'(busy), 64'd1);
    @(negedge clk); #2;
    chk("abort_pulse_single", 64'(abort_cnt - a0), 64'd1);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_grants", 64'(hs_cnt - hs0), 64'd3);

    // Restart after abort
    run_start(32'h0000_2000, 2);
    wait_done("restart_done");

    // Address wrap
    hs0 = hs_cnt;
    run_start(32'hFFFF_FFF8, 2);
    wait_done("wrap_done");
    chk("wrap_grants", 64'(hs_cnt - hs0), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
